// File: rtl/primitive_assembler.sv
// Primitive assembler: groups vertex events into list/strip/fan triangles
// and queues them in a small FIFO for the rasterizer.
// Handshakes: an event is taken on a falling clock edge when I_LOCK & O_Ready.
// A triangle leaves on a falling edge when O_TriValid & I_TriReady.
module primitive_assembler #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      I_CLOCK,
  input  logic                      I_RESET_N,
  input  logic                      I_LOCK,
  input  logic                      I_BeginValid,
  input  logic [3:0]                I_Type,
  input  logic                      I_VertexValid,
  input  logic [4*DATA_WIDTH-1:0]   I_Vertex,
  input  logic [4*DATA_WIDTH-1:0]   I_Color,
  input  logic                      I_EndValid,
  output logic                      O_Ready,
  output logic                      O_TriValid,
  output logic [4*DATA_WIDTH-1:0]   O_TriV0,
  output logic [4*DATA_WIDTH-1:0]   O_TriV1,
  output logic [4*DATA_WIDTH-1:0]   O_TriV2,
  output logic [4*DATA_WIDTH-1:0]   O_TriC0,
  output logic [4*DATA_WIDTH-1:0]   O_TriC1,
  output logic [4*DATA_WIDTH-1:0]   O_TriC2,
  input  logic                      I_TriReady,
  output logic                      O_Busy,
  output logic                      O_Error,
  input  logic                      I_ErrClear,
  output logic [15:0]               O_TriCount,
  output logic                      dbg_state
);

  localparam int VW = 4 * DATA_WIDTH;
  localparam int EW = 6 * VW;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [3:0] T_LIST  = 4'h0;
  localparam logic [3:0] T_STRIP = 4'h1;
  localparam logic [3:0] T_FAN   = 4'h2;

  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_t;

  state_t          state, next_state;
  logic [3:0]      prim_type;
  logic            type_ok;
  logic [1:0]      n;
  logic            parity;
  // h0 is the first vertex of the primitive (fan anchor); p/q are the two most recent.
  logic [VW-1:0]   h0_pos, h0_col, p_pos, p_col, q_pos, q_col;
  logic [AW:0]     wr_ptr, rd_ptr, count;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [EW-1:0]   head, push_data;
  logic            accept, do_begin, do_end, do_vertex;
  logic            push, pop, err_set;

  // Entry layout: {c2, c1, c0, v2, v1, v0}.
  function automatic logic [EW-1:0] pack_tri(
    input logic [VW-1:0] a_pos, input logic [VW-1:0] a_col,
    input logic [VW-1:0] b_pos, input logic [VW-1:0] b_col,
    input logic [VW-1:0] c_pos, input logic [VW-1:0] c_col);
    return {c_col, b_col, a_col, c_pos, b_pos, a_pos};
  endfunction

  assign O_Ready    = (count < (AW+1)'(FIFO_DEPTH));
  assign O_TriValid = (wr_ptr != rd_ptr);
  assign pop        = O_TriValid & I_TriReady;
  assign O_Busy     = (state == OPEN) | O_TriValid;
  assign dbg_state  = state;

  // Event decode: Begin beats End beats Vertex; at most one acts per edge.
  always_comb begin
    accept    = I_LOCK & O_Ready;
    do_begin  = accept & I_BeginValid;
    do_end    = accept & ~I_BeginValid & I_EndValid;
    do_vertex = accept & ~I_BeginValid & ~I_EndValid & I_VertexValid;
  end

  // FSM register.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) state <= IDLE;
    else            state <= next_state;
  end

  // FSM next state plus protocol-error detection.
  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    if (do_begin) begin
      next_state = OPEN;
      if (state == OPEN || I_Type > T_FAN || I_EndValid || I_VertexValid) err_set = 1'b1;
    end else if (do_end) begin
      if (state == OPEN) next_state = IDLE;
      else               err_set    = 1'b1;
      if (I_VertexValid) err_set = 1'b1;
    end else if (do_vertex && state == IDLE) begin
      err_set = 1'b1;
    end
  end

  // Triangle formation from history plus the incoming vertex.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (do_vertex && state == OPEN && type_ok && n >= 2'd2) begin
      push = 1'b1;
      case (prim_type)
        T_LIST:  push_data = pack_tri(p_pos, p_col, q_pos, q_col, I_Vertex, I_Color);
        T_STRIP: push_data = parity ? pack_tri(q_pos, q_col, p_pos, p_col, I_Vertex, I_Color)
                                    : pack_tri(p_pos, p_col, q_pos, q_col, I_Vertex, I_Color);
        default: push_data = pack_tri(h0_pos, h0_col, q_pos, q_col, I_Vertex, I_Color);
      endcase
    end
  end

  // Primitive context: type, vertex index, strip parity and vertex history.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      prim_type <= T_LIST;
      type_ok   <= 1'b0;
      n         <= 2'd0;
      parity    <= 1'b0;
      h0_pos    <= '0;
      h0_col    <= '0;
      p_pos     <= '0;
      p_col     <= '0;
      q_pos     <= '0;
      q_col     <= '0;
    end else if (do_begin) begin
      prim_type <= I_Type;
      type_ok   <= (I_Type <= T_FAN);
      n         <= 2'd0;
      parity    <= 1'b0;
      h0_pos    <= '0;
      h0_col    <= '0;
      p_pos     <= '0;
      p_col     <= '0;
      q_pos     <= '0;
      q_col     <= '0;
    end else if (do_end) begin
      n      <= 2'd0;
      parity <= 1'b0;
    end else if (do_vertex && state == OPEN) begin
      p_pos <= q_pos;
      p_col <= q_col;
      q_pos <= I_Vertex;
      q_col <= I_Color;
      if (n == 2'd0) begin
        h0_pos <= I_Vertex;
        h0_col <= I_Color;
      end
      if (push && prim_type == T_LIST) n <= 2'd0;
      else if (n != 2'd3)              n <= n + 2'd1;
      if (push && prim_type == T_STRIP) parity <= ~parity;
    end
  end

  // FIFO pointers, occupancy and popped-triangle counter.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      O_TriCount <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + (AW+1)'(1);
        O_TriCount <= O_TriCount + 16'd1;
      end
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
    end
  end

  // FIFO storage; contents are don't-care until written since the head is gated.
  always_ff @(negedge I_CLOCK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Sticky error flag; a new error beats a clear in the same cycle.
  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N)      O_Error <= 1'b0;
    else if (err_set)    O_Error <= 1'b1;
    else if (I_ErrClear) O_Error <= 1'b0;
  end

  assign head = O_TriValid ? mem[rd_ptr[AW-1:0]] : '0;
  assign {O_TriC2, O_TriC1, O_TriC0, O_TriV2, O_TriV1, O_TriV0} = head;

endmodule

// File: tb/tb_primitive_assembler.sv
// Directed bench for primitive_assembler: list, strip, fan, back-pressure,
// simultaneous events, asynchronous reset, lock and triangle-count wrap.
module tb_primitive_assembler;

  localparam int TW = 384;
  localparam int K_BEGIN = 0;
  localparam int K_VERT  = 1;
  localparam int K_END   = 2;

  logic          I_CLOCK, I_RESET_N, I_LOCK;
  logic          I_BeginValid, I_VertexValid, I_EndValid;
  logic [3:0]    I_Type;
  logic [63:0]   I_Vertex, I_Color;
  logic          O_Ready, O_TriValid, I_TriReady, O_Busy, O_Error, I_ErrClear;
  logic [63:0]   O_TriV0, O_TriV1, O_TriV2, O_TriC0, O_TriC1, O_TriC2;
  logic [15:0]   O_TriCount;
  logic          dbg_state;
  logic [TW-1:0] head;

  logic [TW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  primitive_assembler #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
    .I_BeginValid(I_BeginValid), .I_Type(I_Type),
    .I_VertexValid(I_VertexValid), .I_Vertex(I_Vertex), .I_Color(I_Color),
    .I_EndValid(I_EndValid), .O_Ready(O_Ready), .O_TriValid(O_TriValid),
    .O_TriV0(O_TriV0), .O_TriV1(O_TriV1), .O_TriV2(O_TriV2),
    .O_TriC0(O_TriC0), .O_TriC1(O_TriC1), .O_TriC2(O_TriC2),
    .I_TriReady(I_TriReady), .O_Busy(O_Busy), .O_Error(O_Error),
    .I_ErrClear(I_ErrClear), .O_TriCount(O_TriCount), .dbg_state(dbg_state)
  );

  assign head = {O_TriC2, O_TriC1, O_TriC0, O_TriV2, O_TriV1, O_TriV0};

  // Clock: state changes on the falling edge, bench drives just after it.
  initial I_CLOCK = 1'b0;
  always #5 I_CLOCK = ~I_CLOCK;

  function automatic logic [63:0] vpos(input int i);
    return {16'(i + 3000), 16'(i + 2000), 16'(i + 1000), 16'(i)};
  endfunction

  function automatic logic [63:0] vcol(input int i);
    return {16'(i + 7000), 16'(i + 6000), 16'(i + 5000), 16'(i + 4000)};
  endfunction

  function automatic logic [TW-1:0] tri3(input int a, input int b, input int c);
    return {vcol(c), vcol(b), vcol(a), vpos(c), vpos(b), vpos(a)};
  endfunction

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every popped triangle must match the oldest expectation.
  always @(posedge I_CLOCK) begin
    if (I_RESET_N && O_TriValid && I_TriReady) begin
      if (exp_q.size() == 0) check("tri_unexpected", TW'(exp_q.size()), TW'(1));
      else                   check("tri", head, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(negedge I_CLOCK);
    #1;
  endtask

  task automatic clear_inputs();
    I_BeginValid  = 1'b0;
    I_VertexValid = 1'b0;
    I_EndValid    = 1'b0;
    I_ErrClear    = 1'b0;
  endtask

  // Present one event and hold it until the assembler takes it.
  task automatic send(input int kind, input int val);
    bit ok;
    clear_inputs();
    I_BeginValid  = (kind == K_BEGIN);
    I_VertexValid = (kind == K_VERT);
    I_EndValid    = (kind == K_END);
    I_Type        = val[3:0];
    I_Vertex      = vpos(val);
    I_Color       = vcol(val);
    ok = 1'b0;
    for (int c = 0; c < 64 && !ok; c++) begin
      if (I_LOCK && O_Ready) ok = 1'b1;
      tick();
    end
    clear_inputs();
    if (!ok) check("send_timeout", TW'(O_Ready), TW'(1));
  endtask

  task automatic drain();
    for (int c = 0; c < 64 && O_TriValid; c++) tick();
    check("drain", TW'(O_TriValid), TW'(0));
  endtask

  initial begin
    I_RESET_N  = 1'b0;
    I_LOCK     = 1'b1;
    I_TriReady = 1'b1;
    I_Type     = 4'h0;
    I_Vertex   = '0;
    I_Color    = '0;
    clear_inputs();
    repeat (3) tick();
    I_RESET_N = 1'b1;
    tick();

    // Reset state
    check("rst_ready", TW'(O_Ready), TW'(1));
    check("rst_valid", TW'(O_TriValid), TW'(0));
    check("rst_head", head, TW'(0));
    check("rst_busy", TW'(O_Busy), TW'(0));
    check("rst_error", TW'(O_Error), TW'(0));
    check("rst_count", TW'(O_TriCount), TW'(0));
    check("rst_state", TW'(dbg_state), TW'(0));

    // List
    exp_q.push_back(tri3(1, 2, 3));
    exp_q.push_back(tri3(4, 5, 6));
    send(K_BEGIN, 0);
    check("list_busy", TW'(O_Busy), TW'(1));
    for (int i = 1; i <= 6; i++) begin
      send(K_VERT, i);
      if (i == 3) begin
        check("list_latency", TW'(O_TriValid), TW'(1));
        check("list_head", head, tri3(1, 2, 3));
      end
    end
    send(K_END, 0);
    drain();
    check("list_count", TW'(O_TriCount), TW'(2));
    check("list_error", TW'(O_Error), TW'(0));
    check("list_idle", TW'(O_Busy), TW'(0));

    // Strip
    exp_q.push_back(tri3(1, 2, 3));
    exp_q.push_back(tri3(3, 2, 4));
    exp_q.push_back(tri3(3, 4, 5));
    send(K_BEGIN, 1);
    for (int i = 1; i <= 5; i++) send(K_VERT, i);
    send(K_END, 0);
    drain();
    check("strip_count", TW'(O_TriCount), TW'(5));

    // Fan, then a vertex outside any primitive
    exp_q.push_back(tri3(1, 2, 3));
    exp_q.push_back(tri3(1, 3, 4));
    exp_q.push_back(tri3(1, 4, 5));
    send(K_BEGIN, 2);
    for (int i = 1; i <= 5; i++) send(K_VERT, i);
    send(K_END, 0);
    drain();
    check("fan_count", TW'(O_TriCount), TW'(8));
    check("fan_no_error", TW'(O_Error), TW'(0));
    send(K_VERT, 9);
    check("stray_vertex_err", TW'(O_Error), TW'(1));
    check("stray_no_tri", TW'(O_TriValid), TW'(0));
    I_ErrClear = 1'b1;
    tick();
    I_ErrClear = 1'b0;
    check("err_clear", TW'(O_Error), TW'(0));
    // New error wins over a simultaneous clear
    I_EndValid = 1'b1;
    I_ErrClear = 1'b1;
    tick();
    clear_inputs();
    check("err_beats_clear", TW'(O_Error), TW'(1));
    I_ErrClear = 1'b1;
    tick();
    I_ErrClear = 1'b0;
    check("err_clear2", TW'(O_Error), TW'(0));

    // Back-pressure: strip of 8 with the rasterizer stalled
    I_TriReady = 1'b0;
    exp_q.push_back(tri3(1, 2, 3));
    exp_q.push_back(tri3(3, 2, 4));
    exp_q.push_back(tri3(3, 4, 5));
    exp_q.push_back(tri3(5, 4, 6));
    exp_q.push_back(tri3(5, 6, 7));
    exp_q.push_back(tri3(7, 6, 8));
    send(K_BEGIN, 1);
    for (int i = 1; i <= 5; i++) send(K_VERT, i);
    check("bp_ready_before_full", TW'(O_Ready), TW'(1));
    send(K_VERT, 6);
    check("bp_full_ready", TW'(O_Ready), TW'(0));
    I_VertexValid = 1'b1;
    I_Vertex      = vpos(7);
    I_Color       = vcol(7);
    repeat (3) tick();
    check("bp_held_ready", TW'(O_Ready), TW'(0));
    check("bp_head_stable", head, tri3(1, 2, 3));
    check("bp_no_pop", TW'(O_TriCount), TW'(8));
    I_TriReady = 1'b1;
    send(K_VERT, 7);
    send(K_VERT, 8);
    send(K_END, 0);
    drain();
    check("bp_all_seen", TW'(exp_q.size()), TW'(0));
    check("bp_count", TW'(O_TriCount), TW'(14));

    // Begin and Vertex together in IDLE: vertex must not be stored
    I_BeginValid  = 1'b1;
    I_Type        = 4'h2;
    I_VertexValid = 1'b1;
    I_Vertex      = vpos(99);
    I_Color       = vcol(99);
    tick();
    clear_inputs();
    check("simul_state", TW'(dbg_state), TW'(1));
    check("simul_error", TW'(O_Error), TW'(1));
    I_TriReady = 1'b0;
    send(K_VERT, 20);
    send(K_VERT, 21);
    check("simul_not_stored", TW'(O_TriValid), TW'(0));
    send(K_VERT, 22);
    check("simul_fan_head", head, tri3(20, 21, 22));
    send(K_VERT, 23);

    // Asynchronous reset mid-primitive, between clock edges
    #2;
    I_RESET_N = 1'b0;
    #1;
    check("arst_valid", TW'(O_TriValid), TW'(0));
    check("arst_head", head, TW'(0));
    check("arst_ready", TW'(O_Ready), TW'(1));
    check("arst_busy", TW'(O_Busy), TW'(0));
    check("arst_error", TW'(O_Error), TW'(0));
    check("arst_count", TW'(O_TriCount), TW'(0));
    check("arst_state", TW'(dbg_state), TW'(0));
    @(posedge I_CLOCK);
    I_RESET_N  = 1'b1;
    I_TriReady = 1'b1;
    tick();

    // Lock: events ignored, FIFO keeps draining
    I_LOCK     = 1'b0;
    I_EndValid = 1'b1;
    repeat (2) tick();
    clear_inputs();
    check("lock_end_ignored", TW'(O_Error), TW'(0));
    I_BeginValid = 1'b1;
    I_Type       = 4'h0;
    repeat (2) tick();
    clear_inputs();
    check("lock_begin_ignored", TW'(dbg_state), TW'(0));
    I_LOCK = 1'b1;
    send(K_BEGIN, 0);
    send(K_VERT, 1);
    send(K_VERT, 2);
    I_LOCK        = 1'b0;
    I_VertexValid = 1'b1;
    I_Vertex      = vpos(3);
    I_Color       = vcol(3);
    repeat (3) tick();
    clear_inputs();
    check("lock_vertex_ignored", TW'(O_TriValid), TW'(0));
    I_LOCK = 1'b1;
    exp_q.push_back(tri3(1, 2, 4));
    send(K_VERT, 4);
    drain();
    I_TriReady = 1'b0;
    exp_q.push_back(tri3(5, 6, 7));
    send(K_VERT, 5);
    send(K_VERT, 6);
    send(K_VERT, 7);
    check("lock_preload", TW'(O_TriValid), TW'(1));
    I_LOCK     = 1'b0;
    I_TriReady = 1'b1;
    drain();
    I_LOCK = 1'b1;
    send(K_END, 0);
    check("lock_count", TW'(O_TriCount), TW'(2));

    // Triangle counter wrap: 65533 more pops reach 16'hFFFF
    send(K_BEGIN, 1);
    for (int i = 1; i <= 65535; i++) begin
      if (i >= 3) begin
        if (((i - 3) % 2) == 0) exp_q.push_back(tri3(i - 2, i - 1, i));
        else                    exp_q.push_back(tri3(i - 1, i - 2, i));
      end
      send(K_VERT, i);
    end
    drain();
    check("wrap_ffff", TW'(O_TriCount), TW'(16'hFFFF));
    exp_q.push_back(tri3(65535, 65534, 65536));
    send(K_VERT, 65536);
    drain();
    check("wrap_zero", TW'(O_TriCount), TW'(0));
    send(K_END, 0);
    check("final_queue", TW'(exp_q.size()), TW'(0));
    check("final_error", TW'(O_Error), TW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/primitive_assembler.md
# primitive_assembler

Primitive assembly stage directly downstream of the geometry stage. Consumes the primitive-begin, vertex (position + color) and primitive-end events that geometry produces and groups vertices into triangles according to the active primitive type: list, strip or fan. Completed triangles are buffered in a small FIFO and handed to the rasterizer over a valid/ready handshake. Back-pressure to geometry is a single ready line.

## Interface
- `DATA_WIDTH`, default 16: width of one fixed-point element (1.8.7).
- `FIFO_DEPTH`, default 4: triangle FIFO entries; power of two, 2 to 16.
- `I_CLOCK`  in  1: stage clock; all state updates on negedge `I_CLOCK`.
- `I_RESET_N`  in  1: reset, asynchronous and active-low.
- `I_LOCK`  in  1: pipeline lock. While 0, all input events are ignored and the FIFO still drains.
- `I_BeginValid`  in  1: begin-primitive event.
- `I_Type`  in  4: primitive type, sampled with `I_BeginValid`.
  - 4'h0 = triangle list.
  - 4'h1 = strip.
  - 4'h2 = fan.
  - Any other value is invalid.
- `I_VertexValid`  in  1: vertex event.
- `I_Vertex`  in  4*DATA_WIDTH: position {w,z,y,x}; x is in bits [15:0].
- `I_Color`  in  4*DATA_WIDTH: color attached to the vertex.
- `I_EndValid`  in  1: end-primitive event.
- `O_Ready`  out  1: events are accepted this cycle. Equals `FIFO count < FIFO_DEPTH`; combinational from the count register.
- `O_TriValid`  out  1: the FIFO head holds a triangle.
- `O_TriV0`, `O_TriV1`, `O_TriV2`  out  4*DATA_WIDTH each: triangle positions.
- `O_TriC0`, `O_TriC1`, `O_TriC2`  out  4*DATA_WIDTH each: triangle colors.
- `I_TriReady`  in  1: the rasterizer accepts the head. A pop occurs when `O_TriValid & I_TriReady`.
- `O_Busy`  out  1: a primitive is open, or the FIFO is non-empty.
- `O_Error`  out  1: sticky protocol-error flag.
- `I_ErrClear`  in  1: synchronous clear of `O_Error`.
- `O_TriCount`  out  16: count of triangles popped; wraps at 16'hFFFF→0.

## Operation
- FSM states: IDLE and OPEN.
- Event accept condition: `I_LOCK & O_Ready`. At most one event is acted on per edge, with priority Begin > End > Vertex. Any lower-priority valid asserted in the same cycle is dropped and sets `O_Error`.
- Begin:
  - In IDLE: latch the type, clear the vertex index `n` and history, go to OPEN.
  - In OPEN: implicitly discard the open primitive, restart with the new type, set `O_Error`.
  - With an invalid type: go to OPEN, accept vertices but emit nothing, set `O_Error`.
- Vertex in IDLE: dropped, `O_Error` set.
- Vertex in OPEN: stored as the pair {pos,color} into a 3-entry history (A, B, C). `n` increments and saturates at 3 for the triangle test.
- List: the emit condition is the third vertex of each group. Output (A,B,C) in arrival order. History is cleared after the emit.
- Strip: every vertex from the third onward emits.
  - Even triangle k: (v[k], v[k+1], v[k+2]).
  - Odd triangle k: (v[k+1], v[k], v[k+2]), which preserves winding.
  - A one-bit parity register toggles per emitted strip triangle.
- Fan: v0 is held.
  - Every vertex i ≥ 2 emits (v0, v[i-1], v[i]).
- End in OPEN: go to IDLE. Leftover vertices that do not form a triangle are discarded silently; this is not an error.
- End in IDLE: ignored, `O_Error` set.
- FIFO: write pointer, read pointer and count, each of width log2(FIFO_DEPTH)+1.
  - A push and a pop on the same edge leave the count unchanged.
  - Because `O_Ready` is low when the FIFO is full, an accepted vertex never overflows it.
- `I_ErrClear` and a new error in the same cycle: the error wins and `O_Error` stays 1.

## Timing
- Reset values:
  - FSM = IDLE.
  - FIFO empty.
  - `O_Ready` = 1.
  - `O_TriValid` = 0.
  - `O_TriV*` and `O_TriC*` = 0.
  - `O_Busy` = 0.
  - `O_Error` = 0.
  - `O_TriCount` = 0.
  - Strip parity = 0, `n` = 0.
- Latency: a triangle-completing vertex accepted at edge t makes `O_TriValid` = 1, with the head data, after edge t (one cycle).
- The head data is stable while `O_TriValid & ~I_TriReady`. The next entry appears on the edge after the pop.
- Full FIFO: `O_Ready` = 0 and no event is accepted. A pop at edge t raises `O_Ready` after t; there is no same-cycle pass-through.
- Reset asserted mid-primitive: the FIFO and history are discarded immediately and asynchronously.
- Pointer wrap-around is modulo FIFO_DEPTH; the extra MSB distinguishes full from empty.

## Test plan
- **List:** Begin type 0, six vertices x=1..6, End, `I_TriReady` = 1. Expect triangles (1,2,3) and (4,5,6), `O_TriCount` = 2, `O_Error` = 0.
- **Strip:** Begin type 1, vertices x=1..5. Expect (1,2,3), (3,2,4), (3,4,5).
- **Fan:** Begin type 2, vertices 1..5. Expect (1,2,3), (1,3,4), (1,4,5). End, then one more vertex: dropped, `O_Error` = 1. Then `I_ErrClear` clears it.
- **Back-pressure:** `I_TriReady` = 0 with a strip of 8 vertices. Expect `O_Ready` to drop after the 4th triangle (vertex 6 accepted, vertex 7 held off). Raise `I_TriReady`. Expect all 6 triangles in order with no loss or duplication.
- **Simultaneous events:** `I_BeginValid` and `I_VertexValid` in the same cycle in IDLE. Expect OPEN state, vertex not stored, `O_Error` = 1. Then a mid-stream `I_RESET_N` pulse: outputs return to their reset values asynchronously.
- **Lock and wrap:** with `I_LOCK` = 0, events are ignored. Preload `O_TriCount` = 16'hFFFF via 65535 pops; the next pop wraps it to 0.
